// File: rtl/icache_fetch_buffer_pkg.sv
// Shared types, constants and FSM encoding for the direct-mapped instruction cache.
package icache_fetch_buffer_pkg;

   typedef logic [31:0] ADDR_TYPE;
   typedef logic [31:0] INST_TYPE;

   localparam logic     TRUE       = 1'b1;
   localparam logic     FALSE      = 1'b0;
   localparam INST_TYPE INST_RESET = '0;
   localparam ADDR_TYPE ADDR_RESET = '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MISS = 2'd1,
      ST_RESP = 2'd2
   } icache_state_e;

   function automatic ADDR_TYPE word_align(input ADDR_TYPE a);
      return a & ~ADDR_TYPE'(3);
   endfunction

endpackage

// File: rtl/icache_fetch_buffer_if.sv
// Fetcher-side and memory-side signals of the instruction cache, bundled for port passing.
interface icache_fetch_buffer_if;
   import icache_fetch_buffer_pkg::*;

   // Fetch requests are accepted only while fetch_ready_out=1; inst_valid_out and
   // mem_done_in are single-cycle pulses, mem_req_out is a level held until mem_done_in.
   logic     fetch_req_in;
   ADDR_TYPE fetch_pc_in;
   logic     fetch_flush_in;
   logic     fetch_ready_out;
   logic     inst_valid_out;
   INST_TYPE inst_out;
   ADDR_TYPE inst_pc_out;
   logic     mem_req_out;
   ADDR_TYPE mem_addr_out;
   logic     mem_done_in;
   INST_TYPE mem_inst_in;

   modport slave (
      input  fetch_req_in, fetch_pc_in, fetch_flush_in, mem_done_in, mem_inst_in,
      output fetch_ready_out, inst_valid_out, inst_out, inst_pc_out, mem_req_out, mem_addr_out
   );

   modport master (
      output fetch_req_in, fetch_pc_in, fetch_flush_in, mem_done_in, mem_inst_in,
      input  fetch_ready_out, inst_valid_out, inst_out, inst_pc_out, mem_req_out, mem_addr_out
   );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, single synchronous write, async valid clear.
module icache_array
   import icache_fetch_buffer_pkg::*;
#(
   parameter int INDEX_WIDTH = 6
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [INDEX_WIDTH-1:0] rd_idx_in,
   output logic                   rd_valid_out,
   output logic [29-INDEX_WIDTH:0] rd_tag_out,
   output INST_TYPE               rd_data_out,
   input  logic                   we_in,
   input  logic [INDEX_WIDTH-1:0] wr_idx_in,
   input  logic [29-INDEX_WIDTH:0] wr_tag_in,
   input  INST_TYPE               wr_data_in
);

   localparam int LINES = 1 << INDEX_WIDTH;

   logic [LINES-1:0]         valid_q;
   logic [29-INDEX_WIDTH:0]  tag_q  [LINES];
   INST_TYPE                 data_q [LINES];

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         valid_q <= '0;
      end else if (we_in) begin
         valid_q[wr_idx_in] <= TRUE;
      end
   end

   // Tag/data need no reset: a line is only consulted once its valid bit is set.
   always_ff @(posedge clk_in) begin
      if (we_in) begin
         tag_q[wr_idx_in]  <= wr_tag_in;
         data_q[wr_idx_in] <= wr_data_in;
      end
   end

   assign rd_valid_out = valid_q[rd_idx_in];
   assign rd_tag_out   = tag_q[rd_idx_in];
   assign rd_data_out  = data_q[rd_idx_in];

endmodule

// File: rtl/icache_fetch_buffer.sv
// Direct-mapped one-word-per-line instruction cache: FSM, cancel flag and output registers.
module icache_fetch_buffer
   import icache_fetch_buffer_pkg::*;
#(
   parameter int INDEX_WIDTH = 6
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   icache_fetch_buffer_if.slave  bus,
   output icache_state_e         state_dbg_out
);

   icache_state_e state_q, state_d;
   logic          cancel_q, cancel_d;
   ADDR_TYPE      pc_q, pc_d;
   logic          inst_valid_q, inst_valid_d;
   INST_TYPE      inst_q, inst_d;
   ADDR_TYPE      inst_pc_q, inst_pc_d;

   logic                    rd_valid;
   logic [29-INDEX_WIDTH:0] rd_tag;
   INST_TYPE                rd_data;
   logic                    hit;
   logic                    refill_we;
   ADDR_TYPE                fetch_pc_aligned;

   assign fetch_pc_aligned = word_align(bus.fetch_pc_in);

   icache_array #(.INDEX_WIDTH(INDEX_WIDTH)) u_array (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rd_idx_in    (bus.fetch_pc_in[INDEX_WIDTH+1:2]),
      .rd_valid_out (rd_valid),
      .rd_tag_out   (rd_tag),
      .rd_data_out  (rd_data),
      .we_in        (refill_we),
      .wr_idx_in    (pc_q[INDEX_WIDTH+1:2]),
      .wr_tag_in    (pc_q[31:INDEX_WIDTH+2]),
      .wr_data_in   (bus.mem_inst_in)
   );

   assign hit       = rd_valid && (rd_tag == bus.fetch_pc_in[31:INDEX_WIDTH+2]);
   assign refill_we = rdy_in && (state_q == ST_MISS) && bus.mem_done_in;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= ST_IDLE;
         cancel_q     <= FALSE;
         pc_q         <= ADDR_RESET;
         inst_valid_q <= FALSE;
         inst_q       <= INST_RESET;
         inst_pc_q    <= ADDR_RESET;
      end else if (rdy_in) begin
         state_q      <= state_d;
         cancel_q     <= cancel_d;
         pc_q         <= pc_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cancel_d     = cancel_q;
      pc_d         = pc_q;
      inst_valid_d = FALSE;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.fetch_req_in && !bus.fetch_flush_in) begin
               if (hit) begin
                  inst_valid_d = TRUE;
                  inst_d       = rd_data;
                  inst_pc_d    = fetch_pc_aligned;
               end else begin
                  pc_d    = fetch_pc_aligned;
                  state_d = ST_MISS;
               end
            end
         end
         ST_MISS: begin
            if (bus.fetch_flush_in) cancel_d = TRUE;
            // The refill always lands in the array; only the delivery is suppressed.
            if (bus.mem_done_in) begin
               state_d      = ST_RESP;
               inst_valid_d = !(cancel_q || bus.fetch_flush_in);
               inst_d       = bus.mem_inst_in;
               inst_pc_d    = pc_q;
            end
         end
         ST_RESP: begin
            cancel_d = FALSE;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A redirect also kills a response already sitting in the output register.
   assign bus.inst_valid_out  = inst_valid_q && !(rdy_in && bus.fetch_flush_in);
   assign bus.inst_out        = inst_q;
   assign bus.inst_pc_out     = inst_pc_q;
   assign bus.fetch_ready_out = (state_q == ST_IDLE);
   assign bus.mem_req_out     = (state_q == ST_MISS);
   assign bus.mem_addr_out    = pc_q;
   assign state_dbg_out       = state_q;

endmodule
